// File: rtl/axi4_lite_master.sv
// axi4_lite_master: one-at-a-time AXI4-Lite master behind a local cmd/rsp handshake.
// Optional watchdog abort is compiled in with `define AXI_MASTER_TIMEOUT_EN.
module axi4_lite_master #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  ACLK,
  input  logic                  rst,
  // Local controller side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDRESS-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  busy,
  // AXI4-Lite write channels
  output logic [ADDRESS-1:0]    M_AWADDR,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  output logic [DATA_WIDTH-1:0] M_WDATA,
  output logic [3:0]            M_WSTRB,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  // AXI4-Lite read channels
  output logic [ADDRESS-1:0]    M_ARADDR,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RVALID,
  output logic                  M_RREADY,
  // Debug view of the controller state
  output logic [2:0]            dbg_state
);

  // Handshake rule on every valid/ready pair (cmd, rsp, AW, W, B, AR, R): a transfer
  // happens on each ACLK edge where both are high; the source keeps its payload stable
  // while valid is high and only lowers valid after the transfer.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RSP   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDRESS-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  write_q, write_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  aw_hs, w_hs;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;
`endif

  assign aw_hs = awvalid_q & M_AWREADY;
  assign w_hs  = wvalid_q & M_WREADY;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    write_d     = write_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
`ifdef AXI_MASTER_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          write_d     = cmd_write;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
`ifdef AXI_MASTER_TIMEOUT_EN
          tmo_cnt_d     = '0;
          rsp_timeout_d = 1'b0;
`endif
          if (cmd_write) begin
            state_d   = S_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      // AW and W complete independently; both must be done before waiting on B.
      S_WRITE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end

      S_WRESP: begin
        if (bready_q && M_BVALID) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_BRESP;
          state_d     = S_RSP;
        end
      end

      S_RADDR: begin
        if (arvalid_q && M_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end

      // Inference reads may stall for a long time; without the watchdog this waits forever.
      S_RDATA: begin
        if (rready_q && M_RVALID) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = M_RDATA;
          rsp_resp_d  = M_RRESP;
          state_d     = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    // The watchdog only fires if this cycle does not already deliver the response.
    if (state_q inside {S_WRITE, S_WRESP, S_RADDR, S_RDATA}) begin
      if ((state_d != S_RSP) && (tmo_cnt_q == TMO_LAST)) begin
        state_d       = S_RSP;
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_write_d   = write_q;
        rsp_rdata_d   = '0;
        rsp_resp_d    = 2'b10;
        rsp_timeout_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      write_q     <= write_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  // Address/data come straight from the command registers; the slave drops bits [1:0].
  assign M_AWADDR  = addr_q;
  assign M_ARADDR  = addr_q;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = wstrb_q;
  assign M_AWVALID = awvalid_q;
  assign M_WVALID  = wvalid_q;
  assign M_BREADY  = bready_q;
  assign M_ARVALID = arvalid_q;
  assign M_RREADY  = rready_q;

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign dbg_state = state_q;

`ifdef AXI_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: behavioural AXI4-Lite slave with programmable waits,
// word-addressed memory reference model, and per-scenario checks.
module tb_axi4_lite_master;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic        ACLK = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
  logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  logic [3:0]  M_WSTRB;
  logic [1:0]  M_BRESP, M_RRESP;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Slave memory (updated from what the DUT puts on the bus) and reference memory
  // (updated from the commands the bench issues).
  logic [31:0] slv_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  // Observations from the most recent transaction
  int          obs_done, obs_rsp_cyc, obs_acc_cyc;
  int          obs_aw_hs, obs_w_hs, obs_b_hs, obs_ar_hs, obs_r_hs;
  int          obs_aw_first, obs_w_first, obs_aw_cyc, obs_w_cyc, obs_w_cycles;
  int          obs_stab_err, obs_hold_err, obs_late_err, obs_after_hs_err;
  logic [31:0] obs_awaddr, obs_wdata, obs_araddr, obs_rdata;
  logic [3:0]  obs_wstrb;
  logic        obs_write, obs_timeout, obs_cmd_ready_after;
  logic [1:0]  obs_resp;

  axi4_lite_master #(.ADDRESS(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
    .ACLK(ACLK), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ref_mem[a[31:2]] = merge(ref_read(a), d, s);
  endtask

  task automatic clear_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0; M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = '0;
    M_ARREADY = 0; M_RVALID = 0; M_RDATA = '0; M_RRESP = '0;
  endtask

  // Driver + slave: issues one command and plays the slave with the given wait cycles.
  // Cycle 0 is the command-handshake cycle.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int d_aw, input int d_w, input int d_b,
                        input int d_ar, input int d_r, input int d_rsp, input logic [1:0] resp);
    int cyc, n, aw_wait, w_wait, ar_wait, rsp_wait, b_at, r_at;
    obs_done = 0; obs_rsp_cyc = -1; obs_acc_cyc = -1;
    obs_aw_hs = 0; obs_w_hs = 0; obs_b_hs = 0; obs_ar_hs = 0; obs_r_hs = 0;
    obs_aw_first = -1; obs_w_first = -1; obs_aw_cyc = -1; obs_w_cyc = -1; obs_w_cycles = 0;
    obs_stab_err = 0; obs_hold_err = 0; obs_late_err = 0; obs_after_hs_err = 0;
    obs_cmd_ready_after = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; rsp_wait = 0; b_at = -1; r_at = -1;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) begin clear_inputs(); return; end
    cyc = 0;
    while (obs_done == 0 && cyc < 300) begin
      @(negedge ACLK);
      cyc++;
      cmd_valid = 0;
      if (obs_acc_cyc >= 0) begin
        obs_cmd_ready_after = cmd_ready;
        if (rsp_valid !== 1'b0) obs_hold_err++;
        obs_done = 1;
        clear_inputs();
      end else begin
        // AW channel
        if (M_AWVALID) begin
          if (obs_aw_first < 0) begin obs_aw_first = cyc; obs_awaddr = M_AWADDR; end
          else if (M_AWADDR !== obs_awaddr) obs_stab_err++;
          if (obs_aw_cyc >= 0) obs_after_hs_err++;
          M_AWREADY = (aw_wait >= d_aw);
          if (M_AWREADY) begin obs_aw_hs++; obs_aw_cyc = cyc; end
          aw_wait++;
        end else M_AWREADY = 0;
        // W channel
        if (M_WVALID) begin
          obs_w_cycles++;
          if (obs_w_first < 0) begin obs_w_first = cyc; obs_wdata = M_WDATA; obs_wstrb = M_WSTRB; end
          else if (M_WDATA !== obs_wdata || M_WSTRB !== obs_wstrb) obs_stab_err++;
          if (obs_w_cyc >= 0) obs_after_hs_err++;
          M_WREADY = (w_wait >= d_w);
          if (M_WREADY) begin obs_w_hs++; obs_w_cyc = cyc; end
          w_wait++;
        end else M_WREADY = 0;
        // B channel: the slave commits the write once both AW and W have arrived
        if (obs_aw_cyc >= 0 && obs_w_cyc >= 0 && b_at < 0) begin
          b_at = ((obs_aw_cyc > obs_w_cyc) ? obs_aw_cyc : obs_w_cyc) + 1 + d_b;
          slv_mem[obs_awaddr[31:2]] = merge(slv_mem.exists(obs_awaddr[31:2]) ?
                                            slv_mem[obs_awaddr[31:2]] : 32'h0, obs_wdata, obs_wstrb);
        end
        M_BVALID = (b_at >= 0 && cyc >= b_at && obs_b_hs == 0);
        M_BRESP  = resp;
        if (M_BVALID && M_BREADY) obs_b_hs++;
        // AR channel
        if (M_ARVALID) begin
          if (obs_ar_hs == 0 && ar_wait == 0) obs_araddr = M_ARADDR;
          else if (M_ARADDR !== obs_araddr) obs_stab_err++;
          if (obs_ar_hs > 0) obs_after_hs_err++;
          M_ARREADY = (ar_wait >= d_ar);
          if (M_ARREADY) begin obs_ar_hs++; r_at = cyc + 1 + d_r; end
          ar_wait++;
        end else M_ARREADY = 0;
        // R channel
        M_RVALID = (r_at >= 0 && cyc >= r_at && obs_r_hs == 0);
        M_RDATA  = slv_mem.exists(obs_araddr[31:2]) ? slv_mem[obs_araddr[31:2]] : 32'h0;
        M_RRESP  = resp;
        if (M_RVALID && M_RREADY) obs_r_hs++;
        // Response side
        if (obs_rsp_cyc >= 0 && (M_AWVALID || M_WVALID || M_BREADY || M_ARVALID || M_RREADY))
          obs_late_err++;
        if (rsp_valid) begin
          if (obs_rsp_cyc < 0) begin
            obs_rsp_cyc = cyc; obs_write = rsp_write; obs_rdata = rsp_rdata;
            obs_resp = rsp_resp; obs_timeout = rsp_timeout;
          end else if (rsp_write !== obs_write || rsp_rdata !== obs_rdata ||
                       rsp_resp !== obs_resp || rsp_timeout !== obs_timeout) obs_hold_err++;
          if (cmd_ready !== 1'b0 || busy !== 1'b1) obs_hold_err++;
          rsp_ready = (rsp_wait >= d_rsp);
          rsp_wait++;
          if (rsp_ready) obs_acc_cyc = cyc;
        end else begin
          if (obs_rsp_cyc >= 0) obs_hold_err++;
          rsp_ready = 0;
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    logic [31:0] outs_or;
    @(negedge ACLK);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0b exp 1", cmd_ready); end
    outs_or = M_AWADDR | M_WDATA | M_ARADDR | rsp_rdata | {28'h0, M_WSTRB} |
              {25'h0, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, busy, rsp_valid} |
              {27'h0, rsp_write, rsp_resp, rsp_timeout};
    checks++;
    if (outs_or !== 32'h0) begin errors++; $display("FAIL reset_outputs got %0h exp 0", outs_or); end
    @(negedge ACLK);
    rst = 0;
    @(negedge ACLK);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got ready=%0b busy=%0b exp 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_zero_wait();
    ref_write(32'h10, 32'h000000A5, 4'hF);
    do_txn(1'b1, 32'h10, 32'h000000A5, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00);
    checks++;
    if (obs_done !== 1) begin errors++; $display("FAIL wr0_done got %0d exp 1", obs_done); end
    checks++;
    if (obs_rsp_cyc !== 3) begin errors++; $display("FAIL wr0_latency got %0d exp 3", obs_rsp_cyc); end
    checks++;
    if (obs_awaddr !== 32'h10 || obs_wdata !== 32'hA5 || obs_wstrb !== 4'hF) begin
      errors++; $display("FAIL wr0_bus got %0h/%0h/%0h exp 10/a5/f", obs_awaddr, obs_wdata, obs_wstrb);
    end
    checks++;
    if (obs_aw_first !== 1 || obs_w_first !== 1) begin
      errors++; $display("FAIL wr0_valid_start got aw=%0d w=%0d exp 1/1", obs_aw_first, obs_w_first);
    end
    checks++;
    if (obs_write !== 1'b1 || obs_resp !== 2'b00 || obs_rdata !== 32'h0 || obs_timeout !== 1'b0) begin
      errors++; $display("FAIL wr0_rsp got w=%0b resp=%0b rd=%0h to=%0b exp 1/00/0/0",
                         obs_write, obs_resp, obs_rdata, obs_timeout);
    end
  endtask

  task automatic test_read_stall();
    slv_mem[30'h18] = 32'h7;
    ref_mem[30'h18] = 32'h7;
    do_txn(1'b0, 32'h60, 32'h0, 4'h0, 0, 0, 0, 3, 39, 0, 2'b00);
    checks++;
    if (obs_rsp_cyc !== 45) begin errors++; $display("FAIL rd_stall_latency got %0d exp 45", obs_rsp_cyc); end
    checks++;
    if (obs_araddr !== 32'h60 || obs_stab_err !== 0 || obs_ar_hs !== 1) begin
      errors++; $display("FAIL rd_stall_ar got addr=%0h stab=%0d hs=%0d exp 60/0/1",
                         obs_araddr, obs_stab_err, obs_ar_hs);
    end
    checks++;
    if (obs_rdata !== ref_read(32'h60) || obs_resp !== 2'b00 || obs_write !== 1'b0) begin
      errors++; $display("FAIL rd_stall_rsp got rd=%0h resp=%0b w=%0b exp %0h/00/0",
                         obs_rdata, obs_resp, obs_write, ref_read(32'h60));
    end
  endtask

  task automatic test_aw_before_w();
    ref_write(32'h24, 32'hDEAD_BEEF, 4'h5);
    do_txn(1'b1, 32'h24, 32'hDEAD_BEEF, 4'h5, 0, 2, 1, 0, 0, 0, 2'b01);
    checks++;
    if (obs_aw_hs !== 1 || obs_w_hs !== 1 || obs_b_hs !== 1) begin
      errors++; $display("FAIL aw_w_hs got aw=%0d w=%0d b=%0d exp 1/1/1", obs_aw_hs, obs_w_hs, obs_b_hs);
    end
    checks++;
    if (obs_after_hs_err !== 0 || obs_w_cycles !== 3) begin
      errors++; $display("FAIL aw_w_valid got after_hs=%0d w_cycles=%0d exp 0/3", obs_after_hs_err, obs_w_cycles);
    end
    checks++;
    if (obs_rsp_cyc !== 6 || obs_resp !== 2'b01) begin
      errors++; $display("FAIL aw_w_rsp got cyc=%0d resp=%0b exp 6/01", obs_rsp_cyc, obs_resp);
    end
  endtask

  task automatic test_rsp_backpressure();
    do_txn(1'b0, 32'h24, 32'h0, 4'h0, 0, 0, 0, 0, 0, 5, 2'b00);
    checks++;
    if (obs_hold_err !== 0 || obs_done !== 1) begin
      errors++; $display("FAIL bp_hold got hold_err=%0d done=%0d exp 0/1", obs_hold_err, obs_done);
    end
    checks++;
    if (obs_cmd_ready_after !== 1'b1) begin
      errors++; $display("FAIL bp_cmd_ready got %0b exp 1", obs_cmd_ready_after);
    end
    checks++;
    if (obs_rdata !== ref_read(32'h24)) begin
      errors++; $display("FAIL bp_rdata got %0h exp %0h", obs_rdata, ref_read(32'h24));
    end
  endtask

  task automatic test_reset_mid_read();
    int n, seen;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h60;
    @(negedge ACLK);
    cmd_valid = 0;
    n = 0;
    while (M_ARVALID !== 1'b1 && n < 10) begin @(negedge ACLK); n++; end
    M_ARREADY = 1;
    @(negedge ACLK);
    M_ARREADY = 0;
    checks++;
    if (M_RREADY !== 1'b1) begin errors++; $display("FAIL rst_mid_rready_before got %0b exp 1", M_RREADY); end
    #2 rst = 1;
    #1;
    checks++;
    if (M_RREADY !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_async got rready=%0b busy=%0b ready=%0b exp 0/0/1",
                         M_RREADY, busy, cmd_ready);
    end
    @(negedge ACLK);
    rst = 0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin @(negedge ACLK); if (rsp_valid !== 1'b0) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_rsp got %0d exp 0", seen); end
    do_txn(1'b0, 32'h60, 32'h0, 4'h0, 0, 0, 0, 1, 2, 0, 2'b00);
    checks++;
    if (obs_done !== 1 || obs_rsp_cyc !== 6 || obs_rdata !== ref_read(32'h60)) begin
      errors++; $display("FAIL rst_mid_after got done=%0d cyc=%0d rd=%0h exp 1/6/%0h",
                         obs_done, obs_rsp_cyc, obs_rdata, ref_read(32'h60));
    end
  endtask

  task automatic test_random();
    logic        wr;
    logic [31:0] a, d, exp_rd;
    logic [3:0]  s;
    logic [1:0]  resp;
    int          d_aw, d_w, d_b, d_ar, d_r, exp_lat, bad;
    for (int t = 0; t < 30; t++) begin
      wr = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 63));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      resp = 2'($urandom_range(0, 3));
      d_aw = $urandom_range(0, 4); d_w = $urandom_range(0, 4); d_b = $urandom_range(0, 3);
      d_ar = $urandom_range(0, 4); d_r = $urandom_range(0, 6);
      if (wr) begin
        ref_write(a, d, s);
        exp_lat = 3 + ((d_aw > d_w) ? d_aw : d_w) + d_b;
        exp_rd = 32'h0;
      end else begin
        exp_lat = 3 + d_ar + d_r;
        exp_rd = ref_read(a);
      end
      do_txn(wr, a, d, s, d_aw, d_w, d_b, d_ar, d_r, $urandom_range(0, 3), resp);
      checks++;
      if (obs_done !== 1 || obs_rsp_cyc !== exp_lat) begin
        errors++; $display("FAIL rnd%0d_latency got done=%0d cyc=%0d exp 1/%0d", t, obs_done, obs_rsp_cyc, exp_lat);
      end
      checks++;
      if (obs_write !== wr || obs_rdata !== exp_rd || obs_resp !== resp) begin
        errors++; $display("FAIL rnd%0d_rsp got w=%0b rd=%0h resp=%0b exp %0b/%0h/%0b",
                           t, obs_write, obs_rdata, obs_resp, wr, exp_rd, resp);
      end
      bad = obs_stab_err + obs_hold_err + obs_late_err + obs_after_hs_err;
      if (wr) begin
        if (obs_awaddr !== a || obs_wdata !== d || obs_wstrb !== s) bad++;
        if (obs_aw_hs != 1 || obs_w_hs != 1 || obs_b_hs != 1 || obs_ar_hs != 0) bad++;
      end else begin
        if (obs_araddr !== a || obs_ar_hs != 1 || obs_r_hs != 1 || obs_aw_hs != 0) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL rnd%0d_protocol got %0d issues exp 0", t, bad); end
    end
  endtask

`ifdef AXI_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    do_txn(1'b1, 32'h30, 32'h1234, 4'hF, 0, 0, 1000, 0, 0, 0, 2'b00);
    checks++;
    if (obs_rsp_cyc !== 17 || obs_b_hs !== 0) begin
      errors++; $display("FAIL tmo_cycle got cyc=%0d b=%0d exp 17/0", obs_rsp_cyc, obs_b_hs);
    end
    checks++;
    if (obs_resp !== 2'b10 || obs_timeout !== 1'b1 || obs_rdata !== 32'h0 || obs_late_err !== 0) begin
      errors++; $display("FAIL tmo_rsp got resp=%0b to=%0b rd=%0h late=%0d exp 10/1/0/0",
                         obs_resp, obs_timeout, obs_rdata, obs_late_err);
    end
  endtask
`endif

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_write_zero_wait();
    test_read_stall();
    test_aw_before_w();
    test_rsp_backpressure();
    test_reset_mid_read();
    test_random();
`ifdef AXI_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
